bf16_mul_arbiter: RTL
=====================

// Module: bf16_mul_arbiter
// PURPOSE
//  Shares one combinational bf16_mul instance between N_REQ requesters (KAN spline/weight lanes).
//  Round-robin arbitration; valid/ready handshakes on every requester and on the single response port.
//  Two-stage pipeline: operand register -> bf16_mul -> result register. Results carry the requester ID.
// PARAMETERS
//  N_REQ    4   number of requesters, >=2
//  ID_W     2   requester-ID width, $clog2(N_REQ)
//  DATA_W   16  bf16 word width, fixed by bf16_mul
//  FLAG_W   4   flag width {NAN,ZERO,INF,NORM}, fixed by bf16_mul
// PORTS
//  i_clk        in   1             clock, rising edge
//  i_rst_n      in   1             asynchronous active-low reset
//  i_req_valid  in   N_REQ         per-requester operand valid
//  i_req_a      in   N_REQ*DATA_W  operand A, requester k at [k*16 +: 16]
//  i_req_b      in   N_REQ*DATA_W  operand B, same packing
//  o_req_ready  out  N_REQ         one-hot (or zero) grant; transfer = valid & ready
//  o_rsp_valid  out  1             result valid
//  i_rsp_ready  in   1             consumer accepts result
//  o_rsp_data   out  DATA_W        product, bf16
//  o_rsp_flag   out  FLAG_W        bf16_mul flag, one-hot
//  o_rsp_id     out  ID_W          requester index of this result
//  o_busy       out  1             any pipeline stage holds a valid entry
// BEHAVIOUR
//  Reset (async assert, sync release): s1_valid=0, s2_valid=0, rr_ptr=N_REQ-1, o_rsp_*=0, o_busy=0.
//  - o_req_ready=0 and o_rsp_valid=0 throughout reset.
//  Enables:
//  - s2_en = !s2_valid | i_rsp_ready.
//  - s1_en = !s1_valid | s2_en.
//  - Combinational path i_rsp_ready -> o_req_ready is intended.
//  Arbitration:
//  - Search i_req_valid starting at rr_ptr+1 (mod N_REQ), wrapping; first set bit wins.
//  - o_req_ready = onehot(winner) & {N_REQ{s1_en}}.
//  - o_req_ready must not depend on the winner's own valid beyond selection.
//  - rr_ptr <= winner only on an accepted transfer; otherwise it holds.
//  Stage 1 (on s1_en):
//  - s1_valid <= |grant.
//  - On a grant, s1_a/s1_b/s1_id load from the winner.
//  - With no grant the payload is don't-care and s1_valid clears.
//  bf16_mul consumes s1_a/s1_b combinationally.
//  Stage 2 (on s2_en):
//  - s2_valid <= s1_valid.
//  - data/flag/id load from bf16_mul outputs and s1_id.
//  - o_rsp_* driven directly from the s2 registers.
//  Latency and throughput:
//  - Accept at edge T -> o_rsp_valid at edge T+2 when unstalled.
//  - Sustains 1 result/cycle when i_rsp_ready=1.
//  Backpressure:
//  - While o_rsp_valid & !i_rsp_ready, o_rsp_data/flag/id are stable.
//  - s1 holds if full; no new grant while s1 is full and stalled.
//  - At most 2 results in flight; none dropped or duplicated.
//  Simultaneous events:
//  - Accept into s1 and drain of s2 in the same cycle is legal.
//  - s1 moves to s2 in that same edge.
//  Fairness: a requester holding valid is granted within N_REQ accepted transfers.
//  Requester protocol:
//  - A deasserted valid without a transfer is legal; no state changes.
//  - Operands are sampled only on the transfer edge.
//  Special values are passed through from bf16_mul unchanged:
//  - NaN -> {sign,7FFF}, flag 4'b1000.
//  - 0*inf -> NaN.
//  - inf -> {sign,7F80}, flag 4'b0010.
//  - zero -> {sign,0000}, flag 4'b0100.
//  Reset mid-operation: in-flight entries are discarded; no partial result is emitted after release.
//  o_busy = s1_valid | s2_valid.
// STRUCTURE
//  Shared package bf16_pkg:
//  - Flag indices NAN=3, ZERO=2, INF=1, NORM=0.
//  - EXP_WIDTH=8, SIG_WIDTH=7, and the canonical NaN/inf/zero encodings.
//  Sub-module rr_arbiter #(N):
//  - Ports: req, ptr, en -> grant (one-hot), winner_id.
//  - Purely combinational; also reused by later lane schedulers.
//  Instances: one bf16_mul, one rr_arbiter; stage registers live in this module.
// TESTING
//  1 Req0 alone: a=3FC0, b=4000, ready held 1.
//    -> rsp 4040, flag 0001, id 0, two cycles after accept.
//  2 All 4 valid continuously from reset, ready=1.
//    -> grants in order 0,1,2,3,0,1...
//    -> each id appears once per 4 responses.
//  3 i_rsp_ready=0 for 5 cycles with req1/req2 valid.
//    -> exactly 2 entries accepted, then o_req_ready=0.
//    -> response stable during the stall.
//    -> after release, ids emitted in accept order, no loss.
//  4 Special values:
//    - a=7F80, b=0000 -> data FFFF|7FFF (sign), flag 1000.
//    - a=7F80, b=BF80 -> FF80, flag 0010.
//    - a=8000, b=4000 -> 8000, flag 0100.
//  5 i_rst_n pulled low asynchronously with s1 and s2 full.
//    -> o_rsp_valid=0 immediately.
//    -> after release, no stale response; rr_ptr restarts so req0 wins first.
//  6 Random valid/ready, 10k cycles, scoreboard against a reference bf16 multiply model.
//    -> all results matched and in order; starvation bound of N_REQ holds.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bf16 definitions: field widths, flag positions, canonical encodings.
package bf16_pkg;

  localparam int EXP_WIDTH   = 8;
  localparam int SIG_WIDTH   = 7;
  localparam int BF16_W      = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int BF16_FLAG_W = 4;
  localparam int EXP_BIAS    = 127;

  // One-hot flag bit positions
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NORM = 0;

  // Magnitudes (sign excluded) of the canonical special results
  localparam logic [BF16_W-2:0] NAN_MAG  = 15'h7FFF;
  localparam logic [BF16_W-2:0] INF_MAG  = 15'h7F80;
  localparam logic [BF16_W-2:0] ZERO_MAG = 15'h0000;

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH-1:0] expo;
    logic [SIG_WIDTH-1:0] frac;
  } bf16_t;

  function automatic logic [BF16_FLAG_W-1:0] flag_onehot(input int idx);
    flag_onehot      = '0;
    flag_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bf16_mul.sv
// Combinational bf16 multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero and results below the normal range flush to zero.
module bf16_mul
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0]      a,
  input  logic [BF16_W-1:0]      b,
  output logic [BF16_W-1:0]      p,
  output logic [BF16_FLAG_W-1:0] flag
);

  bf16_t       op_a, op_b;
  logic        sign;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [15:0] prod;
  logic [9:0]  e_sum;
  logic [6:0]  mant;
  logic        guard, sticky, inc;
  logic [16:0] rounded;
  logic [7:0]  e_out;

  assign op_a   = a;
  assign op_b   = b;
  assign sign   = op_a.sign ^ op_b.sign;
  assign a_zero = (op_a.expo == '0);
  assign b_zero = (op_b.expo == '0);
  assign a_inf  = (op_a.expo == '1) && (op_a.frac == '0);
  assign b_inf  = (op_b.expo == '1) && (op_b.frac == '0);
  assign a_nan  = (op_a.expo == '1) && (op_a.frac != '0);
  assign b_nan  = (op_b.expo == '1) && (op_b.frac != '0);

  // 8x8 significand product lies in [1,4); bit 15 set means renormalise by one
  assign prod  = {1'b1, op_a.frac} * {1'b1, op_b.frac};
  assign e_sum = 10'(op_a.expo) + 10'(op_b.expo) + 10'(prod[15]);

  // Pick the 7 kept fraction bits, round to nearest even; a mantissa carry ripples into the exponent
  always_comb begin
    if (prod[15]) begin
      mant   = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
    end else begin
      mant   = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end
    inc     = guard & (sticky | mant[0]);
    rounded = {e_sum, mant} + 17'(inc);
    e_out   = 8'(rounded[16:7] - 10'(EXP_BIAS));
  end

  // Special operands take priority, then range checks on the rounded biased exponent
  always_comb begin
    p    = '0;
    flag = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      p    = {sign, NAN_MAG};
      flag = flag_onehot(FLAG_NAN);
    end else if (a_inf || b_inf) begin
      p    = {sign, INF_MAG};
      flag = flag_onehot(FLAG_INF);
    end else if (a_zero || b_zero) begin
      p    = {sign, ZERO_MAG};
      flag = flag_onehot(FLAG_ZERO);
    end else if (rounded[16:7] >= 10'(EXP_BIAS + 255)) begin
      p    = {sign, INF_MAG};
      flag = flag_onehot(FLAG_INF);
    end else if (rounded[16:7] <= 10'(EXP_BIAS)) begin
      p    = {sign, ZERO_MAG};
      flag = flag_onehot(FLAG_ZERO);
    end else begin
      p    = {sign, e_out, rounded[6:0]};
      flag = flag_onehot(FLAG_NORM);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
// The grant is gated by en, but the winner index is always reported.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] winner_id
);

  logic found;
  int   idx;

  // First requester at or after ptr+1 (mod N) wins
  always_comb begin
    found     = 1'b0;
    winner_id = '0;
    grant     = '0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        winner_id = W'(idx);
      end
    end
    if (found && en) grant[winner_id] = 1'b1;
  end

endmodule

// File: rtl/bf16_mul_arbiter.sv
// Shares one bf16_mul between N_REQ requesters with round-robin arbitration.
// Pipeline: operand register (s1) -> bf16_mul -> result register (s2).
//
// Handshake: every port uses valid/ready. A transfer happens on a rising edge
// where valid & ready are both high. A producer may raise or drop valid freely
// while no transfer happens; payload is sampled only on the transfer edge.
// o_req_ready is a one-hot grant that may depend combinationally on
// i_req_valid and i_rsp_ready. o_rsp_* hold steady while o_rsp_valid is high
// and i_rsp_ready is low.
module bf16_mul_arbiter
  import bf16_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int DATA_W = BF16_W,
  parameter int FLAG_W = BF16_FLAG_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic [FLAG_W-1:0]       o_rsp_flag,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic                    o_busy
);

  logic              s1_valid, s2_valid;
  logic              s1_en, s2_en;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr, winner_id;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] mul_p;
  logic [FLAG_W-1:0] mul_flag;
  logic [DATA_W-1:0] s2_data;
  logic [FLAG_W-1:0] s2_flag;
  logic [ID_W-1:0]   s2_id;

  // A stage may load when it is empty or when its content moves on this edge
  assign s2_en = !s2_valid || i_rsp_ready;
  assign s1_en = !s1_valid || s2_en;

  // No grant is offered while reset is asserted
  rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .en        (s1_en & i_rst_n),
    .grant     (grant),
    .winner_id (winner_id)
  );

  bf16_mul u_mul (
    .a    (s1_a),
    .b    (s1_b),
    .p    (mul_p),
    .flag (mul_flag)
  );

  assign o_req_ready = grant;
  assign o_rsp_valid = s2_valid;
  assign o_rsp_data  = s2_data;
  assign o_rsp_flag  = s2_flag;
  assign o_rsp_id    = s2_id;
  assign o_busy      = s1_valid | s2_valid;

  // Pointer moves to the winner only when a transfer actually happens
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= ID_W'(N_REQ - 1);
    end else if (|grant) begin
      rr_ptr <= winner_id;
    end
  end

  // Operand stage: capture the granted requester's operands and ID
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_en) begin
      s1_valid <= |grant;
      if (|grant) begin
        s1_a  <= i_req_a[winner_id*DATA_W +: DATA_W];
        s1_b  <= i_req_b[winner_id*DATA_W +: DATA_W];
        s1_id <= winner_id;
      end
    end
  end

  // Result stage: register the product, flag and originating ID
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flag  <= '0;
      s2_id    <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      s2_data  <= mul_p;
      s2_flag  <= mul_flag;
      s2_id    <= s1_id;
    end
  end

endmodule
